// File: rtl/mse_bus_arbiter.sv
// Round-robin two-port Avalon-MM arbiter sharing the MSE host master port.
// One transaction in flight; a granted read keeps the port until its data returns.
module mse_bus_arbiter #(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int BW = 4
) (
  input  logic          csi_MCLK_clk,
  input  logic          rsi_MRST_reset,
  input  logic [AW-1:0] avs_S0_address,
  input  logic [DW-1:0] avs_S0_writedata,
  input  logic [BW-1:0] avs_S0_byteenable,
  input  logic          avs_S0_read,
  input  logic          avs_S0_write,
  output logic          avs_S0_waitrequest,
  output logic [DW-1:0] avs_S0_readdata,
  output logic          avs_S0_readdatavalid,
  input  logic [AW-1:0] avs_S1_address,
  input  logic [DW-1:0] avs_S1_writedata,
  input  logic [BW-1:0] avs_S1_byteenable,
  input  logic          avs_S1_read,
  input  logic          avs_S1_write,
  output logic          avs_S1_waitrequest,
  output logic [DW-1:0] avs_S1_readdata,
  output logic          avs_S1_readdatavalid,
  output logic [AW-1:0] avm_M1_address,
  output logic [DW-1:0] avm_M1_writedata,
  output logic [BW-1:0] avm_M1_byteenable,
  output logic          avm_M1_read,
  output logic          avm_M1_write,
  output logic          avm_M1_begintransfer,
  input  logic [DW-1:0] avm_M1_readdata,
  input  logic          avm_M1_readdatavalid,
  input  logic          avm_M1_waitrequest
);

  // state  | meaning
  // IDLE   | no command outstanding, arbitrate on this cycle's requests
  // XFER   | latched command on avm_M1_*, waiting for slave acceptance
  // RDWAIT | read accepted, waiting for avm_M1_readdatavalid
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RDWAIT} state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic [BW-1:0] be_d;
  logic          read_d, write_d, bt_d;
  logic          req0, req1, sel, sel_rd, sel_wr;

  assign req0 = avs_S0_read | avs_S0_write;
  assign req1 = avs_S1_read | avs_S1_write;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = avm_M1_address;
    wdata_d = avm_M1_writedata;
    be_d    = avm_M1_byteenable;
    read_d  = avm_M1_read;
    write_d = avm_M1_write;
    bt_d    = 1'b0;
    sel     = 1'b0;
    sel_rd  = 1'b0;
    sel_wr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          // on a tie the port that did not win last time gets the bus
          sel     = (req0 & req1) ? ~last_q : req1;
          sel_rd  = sel ? avs_S1_read  : avs_S0_read;
          sel_wr  = sel ? avs_S1_write : avs_S0_write;
          grant_d = sel;
          last_d  = sel;
          addr_d  = sel ? avs_S1_address    : avs_S0_address;
          wdata_d = sel ? avs_S1_writedata  : avs_S0_writedata;
          be_d    = sel ? avs_S1_byteenable : avs_S0_byteenable;
          read_d  = sel_rd;
          write_d = sel_wr & ~sel_rd;
          bt_d    = 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!avm_M1_waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = avm_M1_read ? ST_RDWAIT : ST_IDLE;
        end
      end
      ST_RDWAIT: begin
        if (avm_M1_readdatavalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      state_q              <= ST_IDLE;
      grant_q              <= 1'b0;
      last_q               <= 1'b1;
      avm_M1_address       <= '0;
      avm_M1_writedata     <= '0;
      avm_M1_byteenable    <= '0;
      avm_M1_read          <= 1'b0;
      avm_M1_write         <= 1'b0;
      avm_M1_begintransfer <= 1'b0;
    end else begin
      state_q              <= state_d;
      grant_q              <= grant_d;
      last_q               <= last_d;
      avm_M1_address       <= addr_d;
      avm_M1_writedata     <= wdata_d;
      avm_M1_byteenable    <= be_d;
      avm_M1_read          <= read_d;
      avm_M1_write         <= write_d;
      avm_M1_begintransfer <= bt_d;
    end
  end

  // reset gating keeps both requesters stalled and silent while reset is held
  assign avs_S0_waitrequest = rsi_MRST_reset |
         ~(state_q == ST_XFER && !grant_q && !avm_M1_waitrequest);
  assign avs_S1_waitrequest = rsi_MRST_reset |
         ~(state_q == ST_XFER && grant_q && !avm_M1_waitrequest);

  assign avs_S0_readdata = avm_M1_readdata;
  assign avs_S1_readdata = avm_M1_readdata;

  assign avs_S0_readdatavalid = !rsi_MRST_reset && avm_M1_readdatavalid &&
                                state_q == ST_RDWAIT && !grant_q;
  assign avs_S1_readdatavalid = !rsi_MRST_reset && avm_M1_readdatavalid &&
                                state_q == ST_RDWAIT && grant_q;

endmodule

// File: tb/tb_mse_bus_arbiter.sv
// Directed bench for mse_bus_arbiter: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_mse_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s0_addr, s1_addr, m_addr;
  logic [31:0] s0_wdata, s1_wdata, s0_rdata, s1_rdata, m_wdata, m_rdata;
  logic [3:0]  s0_be, s1_be, m_be;
  logic        s0_rd, s0_wr, s0_wait, s0_rdv;
  logic        s1_rd, s1_wr, s1_wait, s1_rdv;
  logic        m_rd, m_wr, m_bt, m_rdv, m_wait;
  int          vectors = 0;
  int          miscompares = 0;
  int          acc0, acc1;

  mse_bus_arbiter #(.DW(32), .AW(8), .BW(4)) dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst),
    .avs_S0_address(s0_addr), .avs_S0_writedata(s0_wdata), .avs_S0_byteenable(s0_be),
    .avs_S0_read(s0_rd), .avs_S0_write(s0_wr), .avs_S0_waitrequest(s0_wait),
    .avs_S0_readdata(s0_rdata), .avs_S0_readdatavalid(s0_rdv),
    .avs_S1_address(s1_addr), .avs_S1_writedata(s1_wdata), .avs_S1_byteenable(s1_be),
    .avs_S1_read(s1_rd), .avs_S1_write(s1_wr), .avs_S1_waitrequest(s1_wait),
    .avs_S1_readdata(s1_rdata), .avs_S1_readdatavalid(s1_rdv),
    .avm_M1_address(m_addr), .avm_M1_writedata(m_wdata), .avm_M1_byteenable(m_be),
    .avm_M1_read(m_rd), .avm_M1_write(m_wr), .avm_M1_begintransfer(m_bt),
    .avm_M1_readdata(m_rdata), .avm_M1_readdatavalid(m_rdv), .avm_M1_waitrequest(m_wait)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s0_addr = '0; s0_wdata = '0; s0_be = '0; s0_rd = 0; s0_wr = 0;
    s1_addr = '0; s1_wdata = '0; s1_be = '0; s1_rd = 0; s1_wr = 0;
    m_rdata = '0; m_rdv = 1'b0; m_wait = 1'b0;
    step(); step();
    m_rdv = 1'b1;
    @(negedge clk);
    check("rst_s0_wait", s0_wait, 1);
    check("rst_s1_wait", s1_wait, 1);
    check("rst_s0_rdv", s0_rdv, 0);
    check("rst_s1_rdv", s1_rdv, 0);
    check("rst_cmd", {m_rd, m_wr, m_bt}, 0);
    check("rst_addr", m_addr, 0);
    check("rst_wdata", m_wdata, 0);
    check("rst_be", m_be, 0);

    // S0 zero-wait write
    step();
    rst = 1'b0; m_rdv = 1'b0;
    s0_addr = 8'h10; s0_wdata = 32'hDEADBEEF; s0_be = 4'hF; s0_wr = 1'b1;
    @(negedge clk);
    check("wr_idle_s0_wait", s0_wait, 1);
    check("wr_idle_cmd", {m_rd, m_wr, m_bt}, 3'b000);
    step();
    @(negedge clk);
    check("wr_cmd", {m_rd, m_wr, m_bt}, 3'b011);
    check("wr_addr", m_addr, 8'h10);
    check("wr_data", m_wdata, 32'hDEADBEEF);
    check("wr_be", m_be, 4'hF);
    check("wr_s0_wait", s0_wait, 0);
    check("wr_s1_wait", s1_wait, 1);
    step();
    s0_wr = 1'b0;
    @(negedge clk);
    check("wr_done_cmd", {m_rd, m_wr, m_bt}, 3'b000);
    check("wr_done_s0_wait", s0_wait, 1);

    // S1 read, data returns 3 cycles after acceptance
    s1_addr = 8'h20; s1_be = 4'hF; s1_rd = 1'b1;
    step();
    @(negedge clk);
    check("rd1_cmd", {m_rd, m_wr, m_bt}, 3'b101);
    check("rd1_addr", m_addr, 8'h20);
    check("rd1_s1_wait", s1_wait, 0);
    check("rd1_s0_wait", s0_wait, 1);
    step();
    s1_rd = 1'b0;
    @(negedge clk);
    check("rd1_cleared", {m_rd, m_wr, m_bt}, 3'b000);
    check("rd1_wait_a", {s0_rdv, s1_rdv}, 2'b00);
    step();
    @(negedge clk);
    check("rd1_wait_b", {s0_rdv, s1_rdv}, 2'b00);
    step();
    m_rdv = 1'b1; m_rdata = 32'h12345678;
    @(negedge clk);
    check("rd1_s1_rdv", s1_rdv, 1);
    check("rd1_s0_rdv", s0_rdv, 0);
    check("rd1_s1_data", s1_rdata, 32'h12345678);
    step();
    m_rdv = 1'b0;
    @(negedge clk);
    check("rd1_rdv_pulse", {s0_rdv, s1_rdv}, 2'b00);

    // both ports writing continuously: S1 went last, so S0 leads and grants alternate
    s0_addr = 8'hA0; s0_wr = 1'b1;
    s1_addr = 8'hB0; s1_wdata = 32'h0000B0B0; s1_wr = 1'b1;
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      @(negedge clk);
      check("rr_addr", m_addr, (i % 2 == 0) ? 32'hA0 : 32'hB0);
      check("rr_waits", {s0_wait, s1_wait}, (i % 2 == 0) ? 32'b01 : 32'b10);
      if (!s0_wait) acc0++;
      if (!s1_wait) acc1++;
      step();
    end
    s0_wr = 1'b0; s1_wr = 1'b0;
    check("rr_acc0", acc0, 10);
    check("rr_acc1", acc1, 10);

    // S0 read stretched by 5 cycles of slave waitrequest
    m_wait = 1'b1;
    s0_addr = 8'h30; s0_rd = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 5) m_wait = 1'b0;
      @(negedge clk);
      check("st_cmd", {m_rd, m_wr, m_bt}, (k == 0) ? 32'b101 : 32'b100);
      check("st_addr", m_addr, 8'h30);
      check("st_s0_wait", s0_wait, (k < 5) ? 32'd1 : 32'd0);
    end
    step();
    s0_rd = 1'b0;
    @(negedge clk);
    check("st_rdwait_cmd", {m_rd, m_wr, m_bt}, 3'b000);

    // reset while in RDWAIT, stale strobe afterwards
    step();
    rst = 1'b1; m_rdv = 1'b1; m_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rr_rst_rdv", {s0_rdv, s1_rdv}, 2'b00);
    check("rr_rst_wait", {s0_wait, s1_wait}, 2'b11);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("late_rdv", {s0_rdv, s1_rdv}, 2'b00);
    check("late_addr", m_addr, 0);
    check("late_cmd", {m_rd, m_wr, m_bt}, 3'b000);
    check("late_be", m_be, 0);

    // read+write together on S0: read wins
    step();
    m_rdv = 1'b0;
    s0_addr = 8'h04; s0_be = 4'h3; s0_rd = 1'b1; s0_wr = 1'b1;
    step();
    @(negedge clk);
    check("rw_cmd", {m_rd, m_wr, m_bt}, 3'b101);
    check("rw_addr", m_addr, 8'h04);
    check("rw_s0_wait", s0_wait, 0);
    step();
    s0_rd = 1'b0; s0_wr = 1'b0;
    m_rdv = 1'b1; m_rdata = 32'h0BADF00D;
    @(negedge clk);
    check("rw_s0_rdv", s0_rdv, 1);
    check("rw_s0_data", s0_rdata, 32'h0BADF00D);
    check("rw_s1_rdv", s1_rdv, 0);
    step();
    m_rdv = 1'b0;
    @(negedge clk);
    check("rw_final_cmd", {m_rd, m_wr, m_bt}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
